// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port valid/ready arbiter in front of the shared CPU alu
//
// Purpose: shares one alu between REQ0 (execute stage) and REQ1 (branch/aux unit).
//   Grants at most one request per cycle (round-robin or fixed priority), drives the alu
//   operand/opcode inputs, and captures result plus flags into a per-port response register.
// Ports:
//   clock, reset                      rising-edge clock, synchronous active-high reset
//   reqN_valid/ready                  request handshake, N = 0,1
//   reqN_opcode/shamt/a/b             alu opcode, shift amount, operands
//   rspN_valid/ready                  response handshake
//   rspN_result, rspN_flags           captured result, {illegal_op, overflow, isLessThan, isNotEqual}
//   alu_rst, alu_opcode/shamt/a/b     drive the alu instance
//   alu_result, alu_ne/lt/ovf         returned from the alu instance
//   grantN_cnt                        saturating count of accepted requests per port
module alu_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int IN_REG     = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_opcode,
    input  logic [4:0]       req0_shamt,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_opcode,
    input  logic [4:0]       req1_shamt,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    output logic [3:0]       rsp0_flags,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic [3:0]       rsp1_flags,
    output logic             alu_rst,
    output logic [4:0]       alu_opcode,
    output logic [4:0]       alu_shamt,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_result,
    input  logic             alu_ne,
    input  logic             alu_lt,
    input  logic             alu_ovf,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
);

    logic        rr_ptr;          // port preferred on the next contended cycle
    logic        stage_valid;
    logic        stage_port;
    logic [4:0]  stage_opcode;
    logic [4:0]  stage_shamt;
    logic [31:0] stage_a;
    logic [31:0] stage_b;

    logic        elig0, elig1;
    logic        grant0, grant1;
    logic        iss_valid;
    logic        iss_port;
    logic [4:0]  iss_opcode;
    logic [4:0]  iss_shamt;
    logic [31:0] iss_a;
    logic [31:0] iss_b;
    logic [3:0]  iss_flags;
    logic        wr0, wr1;

    assign alu_rst = reset;

    // A port may only be granted if its response slot is guaranteed free at the edge where
    // the result lands. With the stage register that edge is one later, so a port that already
    // has an op in flight must wait; the other port can still issue back to back.
    always_comb begin
        elig0 = !reset && req0_valid && (!rsp0_valid || rsp0_ready);
        elig1 = !reset && req1_valid && (!rsp1_valid || rsp1_ready);
        if (IN_REG != 0 && stage_valid) begin
            if (stage_port) elig1 = 1'b0;
            else            elig0 = 1'b0;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (FIXED_PRIO != 0 || !rr_ptr) grant0 = 1'b1;
            else                            grant1 = 1'b1;
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Issue source: the granted request directly, or the stage register one cycle later.
    always_comb begin
        iss_valid  = 1'b0;
        iss_port   = 1'b0;
        iss_opcode = 5'd0;
        iss_shamt  = 5'd0;
        iss_a      = 32'd0;
        iss_b      = 32'd0;
        if (IN_REG == 0) begin
            if (grant0) begin
                iss_valid  = 1'b1;
                iss_opcode = req0_opcode;
                iss_shamt  = req0_shamt;
                iss_a      = req0_a;
                iss_b      = req0_b;
            end else if (grant1) begin
                iss_valid  = 1'b1;
                iss_port   = 1'b1;
                iss_opcode = req1_opcode;
                iss_shamt  = req1_shamt;
                iss_a      = req1_a;
                iss_b      = req1_b;
            end
        end else if (stage_valid) begin
            iss_valid  = 1'b1;
            iss_port   = stage_port;
            iss_opcode = stage_opcode;
            iss_shamt  = stage_shamt;
            iss_a      = stage_a;
            iss_b      = stage_b;
        end
    end

    assign alu_opcode = iss_opcode;
    assign alu_shamt  = iss_shamt;
    assign alu_a      = iss_a;
    assign alu_b      = iss_b;

    // The alu's overflow output is only meaningful for ADD/SUB.
    assign iss_flags = {iss_opcode > 5'd5,
                        alu_ovf && (iss_opcode == 5'd0 || iss_opcode == 5'd1),
                        alu_lt,
                        alu_ne};
    assign wr0 = iss_valid && !iss_port;
    assign wr1 = iss_valid &&  iss_port;

    always_ff @(posedge clock) begin
        if (reset) begin
            stage_valid  <= 1'b0;
            stage_port   <= 1'b0;
            stage_opcode <= 5'd0;
            stage_shamt  <= 5'd0;
            stage_a      <= 32'd0;
            stage_b      <= 32'd0;
            rr_ptr       <= 1'b0;
        end else begin
            stage_valid <= (IN_REG != 0) && (grant0 || grant1);
            if (grant0 || grant1) begin
                stage_port   <= grant1;
                stage_opcode <= grant1 ? req1_opcode : req0_opcode;
                stage_shamt  <= grant1 ? req1_shamt  : req0_shamt;
                stage_a      <= grant1 ? req1_a      : req0_a;
                stage_b      <= grant1 ? req1_b      : req0_b;
            end
            if (grant0)      rr_ptr <= 1'b1;
            else if (grant1) rr_ptr <= 1'b0;
        end
    end

    // A landing result wins over the handshake clear, so valid stays high with new data.
    always_ff @(posedge clock) begin
        if (reset) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= 32'd0;
            rsp0_flags  <= 4'd0;
        end else if (wr0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
            rsp0_flags  <= iss_flags;
        end else if (rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= 32'd0;
            rsp1_flags  <= 4'd0;
        end else if (wr1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
            rsp1_flags  <= iss_flags;
        end else if (rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
        end else begin
            if (grant0 && grant0_cnt != '1) grant0_cnt <= grant0_cnt + 1'b1;
            if (grant1 && grant1_cnt != '1) grant1_cnt <= grant1_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (RR, fixed-prio and staged configs)
module tb_alu_arbiter;

    localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_AND = 5'd2, OP_OR = 5'd3,
                           OP_SRA = 5'd5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // index [d][p]: d0 = RR/IN_REG0, d1 = FIXED_PRIO/CNT_W3, d2 = RR/IN_REG1
    logic        req_valid  [3][2];
    logic        req_ready  [3][2];
    logic [4:0]  req_op     [3][2];
    logic [4:0]  req_sh     [3][2];
    logic [31:0] req_a      [3][2];
    logic [31:0] req_b      [3][2];
    logic        rsp_valid  [3][2];
    logic        rsp_ready  [3][2];
    logic [31:0] rsp_result [3][2];
    logic [3:0]  rsp_flags  [3][2];
    logic [15:0] cnt        [3][2];
    logic        alu_rst [3];
    logic [4:0]  alu_op  [3];
    logic [4:0]  alu_sh  [3];
    logic [31:0] alu_a   [3];
    logic [31:0] alu_b   [3];
    logic [31:0] alu_res [3];
    logic        alu_ne  [3];
    logic        alu_lt  [3];
    logic        alu_ovf [3];

    // Behavioural alu: lt only from the subtract path; overflow line is garbage for logic ops.
    function automatic logic [34:0] alu_fn(input logic [4:0] op, input logic [4:0] sh,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic ne, lt, ovf;
        r = 32'd0; lt = 1'b0; ne = (a != b); ovf = 1'b0;
        case (op)
            5'd0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]);
                        lt = $signed(a) < $signed(b); end
            5'd2: begin r = a & b; ovf = r[31]; end
            5'd3: begin r = a | b; ovf = r[31]; end
            5'd4: begin r = a << sh; ovf = r[31]; end
            5'd5: begin r = $signed(a) >>> sh; ovf = r[31]; end
            default: r = 32'd0;
        endcase
        return {r, ne, lt, ovf};
    endfunction

    function automatic logic [35:0] exp_rsp(input logic [4:0] op, input logic [4:0] sh,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [34:0] m;
        m = alu_fn(op, sh, a, b);
        return {m[34:3], op > 5'd5, m[0] && (op < 5'd2), m[1], m[2]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gd
        localparam int W = (g == 1) ? 3 : 16;
        logic [W-1:0] c0, c1;
        alu_arbiter #(.FIXED_PRIO(g == 1 ? 1 : 0), .IN_REG(g == 2 ? 1 : 0), .CNT_W(W)) dut (
            .clock(clk), .reset(reset),
            .req0_valid(req_valid[g][0]), .req0_ready(req_ready[g][0]),
            .req0_opcode(req_op[g][0]), .req0_shamt(req_sh[g][0]),
            .req0_a(req_a[g][0]), .req0_b(req_b[g][0]),
            .req1_valid(req_valid[g][1]), .req1_ready(req_ready[g][1]),
            .req1_opcode(req_op[g][1]), .req1_shamt(req_sh[g][1]),
            .req1_a(req_a[g][1]), .req1_b(req_b[g][1]),
            .rsp0_valid(rsp_valid[g][0]), .rsp0_ready(rsp_ready[g][0]),
            .rsp0_result(rsp_result[g][0]), .rsp0_flags(rsp_flags[g][0]),
            .rsp1_valid(rsp_valid[g][1]), .rsp1_ready(rsp_ready[g][1]),
            .rsp1_result(rsp_result[g][1]), .rsp1_flags(rsp_flags[g][1]),
            .alu_rst(alu_rst[g]), .alu_opcode(alu_op[g]), .alu_shamt(alu_sh[g]),
            .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_result(alu_res[g]),
            .alu_ne(alu_ne[g]), .alu_lt(alu_lt[g]), .alu_ovf(alu_ovf[g]),
            .grant0_cnt(c0), .grant1_cnt(c1)
        );
        assign cnt[g][0] = 16'(c0);
        assign cnt[g][1] = 16'(c1);
        assign {alu_res[g], alu_ne[g], alu_lt[g], alu_ovf[g]} =
            alu_fn(alu_op[g], alu_sh[g], alu_a[g], alu_b[g]);
    end

    typedef struct { int d; int p; logic [35:0] v; } sb_t;
    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input int p, input logic v, input logic [4:0] op,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        req_valid[d][p] = v; req_op[d][p] = op; req_sh[d][p] = sh;
        req_a[d][p] = a; req_b[d][p] = b;
    endtask

    // One clock: mid-cycle, pop/compare handshaked responses and push expectations for
    // accepted requests; then advance to just after the next rising edge.
    task automatic cyc();
        logic [35:0] e;
        bit found;
        @(negedge clk);
        if (reset) begin
            sbq.delete();
        end else begin
            for (int d = 0; d < 3; d++) begin
                for (int p = 0; p < 2; p++) begin
                    if (rsp_valid[d][p] && rsp_ready[d][p]) begin
                        found = 0; e = '0;
                        for (int i = 0; i < sbq.size(); i++) begin
                            if (!found && sbq[i].d == d && sbq[i].p == p) begin
                                e = sbq[i].v; sbq.delete(i); found = 1;
                            end
                        end
                        chk($sformatf("sb_expected_d%0d_p%0d", d, p), 64'(found), 64'd1);
                        if (found)
                            chk($sformatf("sb_rsp_d%0d_p%0d", d, p),
                                {rsp_result[d][p], rsp_flags[d][p]}, e);
                    end
                    if (req_valid[d][p] && req_ready[d][p])
                        sbq.push_back('{d, p, exp_rsp(req_op[d][p], req_sh[d][p],
                                                      req_a[d][p], req_b[d][p])});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 2; p++) begin
                drive(d, p, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
                rsp_ready[d][p] = 1'b0;
            end

        // reset: a pending request must not be granted, everything cleared
        drive(0, 0, 1'b1, OP_ADD, 5'd0, 32'd1, 32'd1);
        cyc();
        chk("rst_ready_gated", req_ready[0][0], 1'b0);
        chk("rst_alu_rst", alu_rst[0], 1'b1);
        chk("rst_alu_a_idle", alu_a[0], 32'd0);
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rst_rsp_valid_d%0d_p%0d", d, p), rsp_valid[d][p], 1'b0);
                chk($sformatf("rst_rsp_result_d%0d_p%0d", d, p), rsp_result[d][p], 32'd0);
                chk($sformatf("rst_cnt_d%0d_p%0d", d, p), cnt[d][p], 16'd0);
            end
        req_valid[0][0] = 1'b0;
        reset = 1'b0;
        cyc();
        chk("alu_rst_low", alu_rst[0], 1'b0);

        // single ADD, latency 1, response held under backpressure
        drive(0, 0, 1'b1, OP_ADD, 5'd0, 32'd5, 32'd7);
        #1;
        chk("t1_ready0", req_ready[0][0], 1'b1);
        chk("t1_alu_a_comb", alu_a[0], 32'd5);
        cyc();
        req_valid[0][0] = 1'b0;
        chk("t1_rsp_valid", rsp_valid[0][0], 1'b1);
        chk("t1_result", rsp_result[0][0], 32'd12);
        chk("t1_flags", rsp_flags[0][0], 4'b0001);
        chk("t1_alu_idle", alu_a[0], 32'd0);
        cyc();
        chk("t1_hold_valid", rsp_valid[0][0], 1'b1);
        chk("t1_hold_result", rsp_result[0][0], 32'd12);
        rsp_ready[0][0] = 1'b1;
        cyc();
        chk("t1_cleared", rsp_valid[0][0], 1'b0);
        drive(0, 0, 1'b1, OP_AND, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        cyc();
        req_valid[0][0] = 1'b0;
        chk("t1_and_result", rsp_result[0][0], 32'h8000_0000);
        chk("t1_and_ovf_gated", rsp_flags[0][0], 4'b0001);
        cyc();

        // round-robin contention
        do_reset();
        rsp_ready[0][0] = 1'b1; rsp_ready[0][1] = 1'b1;
        drive(0, 0, 1'b1, OP_ADD, 5'd0, 32'd10, 32'd20);
        drive(0, 1, 1'b1, OP_SRA, 5'd4, 32'h8000_0000, 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_ready0_c%0d", i), req_ready[0][0], 1'((i % 2) == 0));
            chk($sformatf("rr_ready1_c%0d", i), req_ready[0][1], 1'((i % 2) == 1));
            cyc();
        end
        req_valid[0][0] = 1'b0; req_valid[0][1] = 1'b0;
        chk("rr_sra_result", rsp_result[0][1], 32'hF800_0000);
        chk("rr_sra_flags", rsp_flags[0][1], 4'b0001);
        chk("rr_cnt0", cnt[0][0], 16'd2);
        chk("rr_cnt1", cnt[0][1], 16'd2);
        cyc();

        // backpressure on port 1, SUB overflow and illegal opcode
        do_reset();
        rsp_ready[0][0] = 1'b1; rsp_ready[0][1] = 1'b0;
        drive(0, 1, 1'b1, OP_SUB, 5'd0, 32'h8000_0000, 32'd1);
        #1;
        chk("bp_ready1_first", req_ready[0][1], 1'b1);
        cyc();
        chk("sub_valid", rsp_valid[0][1], 1'b1);
        chk("sub_result", rsp_result[0][1], 32'h7FFF_FFFF);
        chk("sub_flags", rsp_flags[0][1], 4'b0111);
        drive(0, 1, 1'b1, 5'd7, 5'd0, 32'd3, 32'd3);
        drive(0, 0, 1'b1, OP_ADD, 5'd0, 32'd1, 32'd2);
        #1;
        chk("bp_ready1_blocked", req_ready[0][1], 1'b0);
        chk("bp_ready0_served", req_ready[0][0], 1'b1);
        cyc();
        rsp_ready[0][1] = 1'b1;
        #1;
        chk("bp_release_ready1", req_ready[0][1], 1'b1);
        chk("bp_release_ready0", req_ready[0][0], 1'b0);
        cyc();
        req_valid[0][1] = 1'b0;
        chk("ill_valid_kept", rsp_valid[0][1], 1'b1);
        chk("ill_result", rsp_result[0][1], 32'd0);
        chk("ill_flags", rsp_flags[0][1], 4'b1000);
        #1;
        chk("bp_ready0_after", req_ready[0][0], 1'b1);
        cyc();
        req_valid[0][0] = 1'b0;
        cyc();
        cyc();
        chk("bp_drained0", rsp_valid[0][0], 1'b0);
        chk("bp_drained1", rsp_valid[0][1], 1'b0);

        // fixed priority and counter saturation (CNT_W = 3)
        do_reset();
        rsp_ready[1][0] = 1'b1; rsp_ready[1][1] = 1'b1;
        drive(1, 0, 1'b1, OP_OR, 5'd0, 32'h0000_00F0, 32'h0000_000F);
        drive(1, 1, 1'b1, OP_ADD, 5'd0, 32'd40, 32'd2);
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("fp_ready0_c%0d", i), req_ready[1][0], 1'b1);
            chk($sformatf("fp_ready1_c%0d", i), req_ready[1][1], 1'b0);
            cyc();
            if (i == 6) chk("fp_cnt0_at_max", cnt[1][0], 16'd7);
        end
        chk("fp_cnt0_saturated", cnt[1][0], 16'd7);
        req_valid[1][0] = 1'b0;
        #1;
        chk("fp_ready1_alone", req_ready[1][1], 1'b1);
        cyc();
        req_valid[1][1] = 1'b0;
        chk("fp_cnt1", cnt[1][1], 16'd1);
        cyc();

        // operand register stage: latency 2, cross-port pipelining
        do_reset();
        rsp_ready[2][0] = 1'b0; rsp_ready[2][1] = 1'b1;
        drive(2, 0, 1'b1, OP_ADD, 5'd0, 32'd1, 32'd1);
        #1;
        chk("ir_ready0", req_ready[2][0], 1'b1);
        chk("ir_alu_idle_at_grant", alu_a[2], 32'd0);
        cyc();
        drive(2, 1, 1'b1, OP_ADD, 5'd0, 32'd2, 32'd3);
        #1;
        chk("ir_ready0_stage_busy", req_ready[2][0], 1'b0);
        chk("ir_ready1_pipelined", req_ready[2][1], 1'b1);
        chk("ir_alu_a_from_stage", alu_a[2], 32'd1);
        chk("ir_not_yet_valid", rsp_valid[2][0], 1'b0);
        cyc();
        req_valid[2][1] = 1'b0;
        #1;
        chk("ir_rsp0_valid", rsp_valid[2][0], 1'b1);
        chk("ir_rsp0_result", rsp_result[2][0], 32'd2);
        chk("ir_rsp0_flags", rsp_flags[2][0], 4'b0000);
        chk("ir_ready0_full", req_ready[2][0], 1'b0);
        chk("ir_alu_a_port1", alu_a[2], 32'd2);
        req_valid[2][0] = 1'b0;
        cyc();
        chk("ir_rsp1_result", rsp_result[2][1], 32'd5);
        chk("ir_rsp1_flags", rsp_flags[2][1], 4'b0001);
        chk("ir_alu_idle", alu_a[2], 32'd0);
        rsp_ready[2][0] = 1'b1;
        cyc();
        cyc();

        // reset one cycle after accept discards the in-flight op
        drive(2, 0, 1'b1, OP_ADD, 5'd0, 32'd1, 32'd1);
        cyc();
        req_valid[2][0] = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_valid", rsp_valid[2][0], 1'b0);
        chk("mid_rst_cnt", cnt[2][0], 16'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("mid_rst_no_stale_c%0d", i), rsp_valid[2][0], 1'b0);
        end

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
